aes_ctr_block_feeder: RTL and testbench

Upstream feeder for the pipelined AES-256 encryption core in CTR mode. It accepts one command: a 96-bit nonce, a 32-bit initial counter and a block count. It then generates consecutive counter blocks {nonce, counter} and presents them on the core's plain_text/start_conversion inputs, one block per 8-cycle pipeline slot. After the final block it holds last_conversion until the core reports done_conversion, then returns to idle.

---
 rtl/aes_ctr_block_feeder.sv | 154 +++++++++++++++
 tb/tb_aes_ctr_block_feeder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/aes_ctr_block_feeder.sv
// CTR-mode counter-block feeder for the pipelined AES-256 core: one block per SLOT_CYCLES slot.
// Optional: define AES_FEEDER_WRAP_STOP_EN to stop issuing (and flag ctr_wrap) on 32-bit counter wrap.
module aes_ctr_block_feeder #(
  parameter int unsigned SLOT_CYCLES = 8,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [95:0]      nonce,
  input  logic [31:0]      ctr_init,
  input  logic [CNT_W-1:0] num_blocks,
  input  logic             pipe_ready,
  input  logic             done_conversion,
  output logic [127:0]     plain_text,
  output logic             start_conversion,
  output logic             last_conversion,
  output logic [CNT_W-1:0] blocks_issued,
  output logic             busy,
  output logic             ctr_wrap
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_PIPE = 2'd1;
  localparam logic [1:0] ISSUE     = 2'd2;
  localparam logic [1:0] DRAIN     = 2'd3;

  localparam logic [7:0] SLOT_LAST = 8'(SLOT_CYCLES - 1);

  logic [1:0]       state_q,  state_d;
  logic [7:0]       slot_q,   slot_d;
  logic [31:0]      ctr_q,    ctr_d;
  logic [95:0]      nonce_q,  nonce_d;
  logic [CNT_W-1:0] num_q,    num_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [127:0]     pt_q,     pt_d;
  logic             start_q,  start_d;
  logic [CNT_W-1:0] issued_inc;
  logic             issue;
  logic             stop_wrap;

`ifdef AES_FEEDER_WRAP_STOP_EN
  logic wrap_q, wrap_d;
  assign stop_wrap = wrap_q;
`else
  assign stop_wrap = 1'b0;
`endif

  assign issued_inc = issued_q + CNT_W'(1);

  // The edge that leaves WAIT_PIPE already issues slot 0, so the first pulse
  // lands one cycle after pipe_ready is seen; later issues happen on slot wrap.
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    ctr_d    = ctr_q;
    nonce_d  = nonce_q;
    num_d    = num_q;
    issued_d = issued_q;
    pt_d     = pt_q;
    start_d  = 1'b0;
    issue    = 1'b0;
`ifdef AES_FEEDER_WRAP_STOP_EN
    wrap_d   = wrap_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          nonce_d  = nonce;
          ctr_d    = ctr_init;
          num_d    = num_blocks;
          issued_d = '0;
`ifdef AES_FEEDER_WRAP_STOP_EN
          wrap_d   = 1'b0;
`endif
          state_d  = (num_blocks == '0) ? IDLE : WAIT_PIPE;
        end
      end
      WAIT_PIPE: begin
        if (pipe_ready) begin
          issue   = 1'b1;
          slot_d  = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (issued_q == num_q || stop_wrap) begin
          state_d = DRAIN;
        end else if (slot_q == SLOT_LAST) begin
          issue  = 1'b1;
          slot_d = '0;
        end else begin
          slot_d = slot_q + 8'd1;
        end
      end
      DRAIN: begin
        if (done_conversion) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      pt_d     = {nonce_q, ctr_q};
      start_d  = 1'b1;
      issued_d = issued_inc;
      ctr_d    = ctr_q + 32'd1;
`ifdef AES_FEEDER_WRAP_STOP_EN
      if (ctr_q == '1 && issued_inc != num_q) begin
        wrap_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      slot_q   <= '0;
      ctr_q    <= '0;
      nonce_q  <= '0;
      num_q    <= '0;
      issued_q <= '0;
      pt_q     <= '0;
      start_q  <= 1'b0;
`ifdef AES_FEEDER_WRAP_STOP_EN
      wrap_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      ctr_q    <= ctr_d;
      nonce_q  <= nonce_d;
      num_q    <= num_d;
      issued_q <= issued_d;
      pt_q     <= pt_d;
      start_q  <= start_d;
`ifdef AES_FEEDER_WRAP_STOP_EN
      wrap_q   <= wrap_d;
`endif
    end
  end

  assign cmd_ready        = (state_q == IDLE);
  assign busy             = (state_q != IDLE);
  assign last_conversion  = (state_q == DRAIN);
  assign plain_text       = pt_q;
  assign start_conversion = start_q;
  assign blocks_issued    = issued_q;
  assign ctr_wrap         = stop_wrap;

endmodule

// File: tb/tb_aes_ctr_block_feeder.sv
// Directed, table-driven bench for aes_ctr_block_feeder (SLOT_CYCLES=8, CNT_W=16).
module tb_aes_ctr_block_feeder;

  localparam int SLOT = 8;

`ifdef AES_FEEDER_WRAP_STOP_EN
  localparam int WRAP_N    = 2;
  localparam bit WRAP_FLAG = 1'b1;
`else
  localparam int WRAP_N    = 4;
  localparam bit WRAP_FLAG = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [95:0]   nonce;
  logic [31:0]   ctr_init;
  logic [15:0]   num_blocks;
  logic          pipe_ready;
  logic          done_conversion;
  logic [127:0]  plain_text;
  logic          start_conversion;
  logic          last_conversion;
  logic [15:0]   blocks_issued;
  logic          busy;
  logic          ctr_wrap;

  int n_checks = 0;
  int n_pass   = 0;

  aes_ctr_block_feeder #(.SLOT_CYCLES(SLOT), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .nonce(nonce), .ctr_init(ctr_init), .num_blocks(num_blocks),
    .pipe_ready(pipe_ready), .done_conversion(done_conversion),
    .plain_text(plain_text), .start_conversion(start_conversion),
    .last_conversion(last_conversion), .blocks_issued(blocks_issued),
    .busy(busy), .ctr_wrap(ctr_wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [95:0] nonce;
    logic [31:0] ctr;
    logic [15:0] num;
    int          pd;          // cycles pipe_ready stays low after accept
    int          dd;          // cycles in DRAIN before done_conversion
    bit          spur;        // pulse done_conversion during ISSUE
    int          exp_n;
    logic [15:0] exp_issued;
    bit          exp_wrap;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, 128'(cmd_ready), 128'(1));
    chk({tag, "_plain_text"}, plain_text, '0);
    chk({tag, "_start"}, 128'(start_conversion), 128'(0));
    chk({tag, "_last"}, 128'(last_conversion), 128'(0));
    chk({tag, "_issued"}, 128'(blocks_issued), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_wrap"}, 128'(ctr_wrap), 128'(0));
  endtask

  task automatic run_vec(input vec_t v);
    int pulses    = 0;
    int last_p    = -1;
    int last_rise = -1;
    int bad       = 0;
    int c         = 1;
    int budget;
    nonce      = v.nonce;
    ctr_init   = v.ctr;
    num_blocks = v.num;
    pipe_ready = (v.pd == 0);
    done_conversion = 1'b0;
    cmd_valid  = 1'b1;
    tick();
    cmd_valid  = 1'b0;
    chk("accept_busy", 128'(busy), 128'(v.num != 0));
    chk("accept_cmd_ready", 128'(cmd_ready), 128'(v.num == 0));
    budget = 2 + v.pd + v.exp_n * SLOT + 16;
    while (c <= budget && last_rise < 0) begin
      if (c == 1 + v.pd) pipe_ready = 1'b1;
      done_conversion = (v.spur && c == 2 + v.pd + 4);
      if (start_conversion) begin
        chk("pulse_time", 128'(c), 128'(2 + v.pd + pulses * SLOT));
        chk("pulse_word", plain_text, {v.nonce, v.ctr + 32'(pulses)});
        pulses++;
        last_p = c;
      end
      if (last_conversion) last_rise = c;
      else begin
        tick();
        c++;
      end
    end
    chk("pulse_count", 128'(pulses), 128'(v.exp_n));
    if (v.num == 0) begin
      chk("zero_no_last", 128'(last_rise), 128'(-1));
      chk("zero_cmd_ready", 128'(cmd_ready), 128'(1));
      chk("zero_issued", 128'(blocks_issued), 128'(0));
    end else begin
      chk("last_rise", 128'(last_rise), 128'(last_p + 1));
      done_conversion = 1'b0;
      for (int i = 0; i < v.dd; i++) begin
        tick();
        if (!last_conversion || start_conversion) bad++;
      end
      chk("drain_hold", 128'(bad), 128'(0));
      done_conversion = 1'b1;
      tick();
      done_conversion = 1'b0;
      chk("done_last", 128'(last_conversion), 128'(0));
      chk("done_busy", 128'(busy), 128'(0));
      chk("done_cmd_ready", 128'(cmd_ready), 128'(1));
      chk("done_issued", 128'(blocks_issued), 128'(v.exp_issued));
      chk("done_wrap", 128'(ctr_wrap), 128'(v.exp_wrap));
    end
  endtask

  initial begin
    vec_t v7;
    int   seen;
    vecs[0] = '{96'hA5A5A5A5_A5A5A5A5_A5A5A5A5, 32'd1, 16'd3, 0, 21, 1'b0, 3, 16'd3, 1'b0};
    vecs[1] = '{96'h0123456789AB_CDEF01234567, 32'h1000, 16'd2, 50, 4, 1'b0, 2, 16'd2, 1'b0};
    vecs[2] = '{96'hDEADBEEF_00000000_CAFEF00D, 32'd9, 16'd0, 0, 0, 1'b0, 0, 16'd0, 1'b0};
    vecs[3] = '{96'h111111112222222233333333, 32'hFFFFFFFE, 16'd4, 0, 3, 1'b0,
                WRAP_N, 16'(WRAP_N), WRAP_FLAG};
    vecs[4] = '{96'h0F0F0F0F_F0F0F0F0_0F0F0F0F, 32'd55, 16'd3, 0, 5, 1'b1, 3, 16'd3, 1'b0};
    vecs[5] = '{96'h000000000000000000000042, 32'd200, 16'd1, 0, 0, 1'b0, 1, 16'd1, 1'b0};

    reset = 1'b1;
    cmd_valid = 1'b0;
    nonce = '0;
    ctr_init = '0;
    num_blocks = '0;
    pipe_ready = 1'b0;
    done_conversion = 1'b0;
    tick();
    tick();
    check_reset_vals("por");
    reset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i]);
      tick();
    end

    // asynchronous reset in the middle of a 5-block run
    nonce = 96'hABCDEF;
    ctr_init = 32'd100;
    num_blocks = 16'd5;
    pipe_ready = 1'b1;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 40 && seen < 2; i++) begin
      if (start_conversion) seen++;
      if (seen < 2) tick();
    end
    chk("mid_seen_two", 128'(seen), 128'(2));
    tick();
    tick();
    tick();
    #2 reset = 1'b1;
    #1 check_reset_vals("async");
    #2 reset = 1'b0;
    v7 = '{96'h777777777777777777777777, 32'd7, 16'd2, 0, 2, 1'b0, 2, 16'd2, 1'b0};
    run_vec(v7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
